// File: rtl/riscv_wait_mem.sv
// Word-organised instruction/data memory for the RISC-V core with byte-lane writes and programmable wait states.
// Optional build macro MEM_BOUNDS_CHECK_EN: out-of-range accesses are blocked, read as zero and raise a sticky mem_err.
module riscv_wait_mem #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RD,
        WAIT_WR
    } state_t;

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic          oob_q, oob_d;

    logic [AW-1:0] idx_in;
    logic          wr_req;
    logic          accept;
    logic          oob_in;
    logic          we;
    logic [AW-1:0] we_idx;
    logic [31:0]   we_data;
    logic [3:0]    we_mask;
    logic          unused_addr_bits;

    assign idx_in           = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};
    assign wr_req           = |mem_wmask;
    // Requests are only taken in IDLE; anything arriving while busy is dropped, not queued.
    assign accept           = resetn && (state_q == IDLE) && (wr_req || mem_rstrb);

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

    logic err_q, err_d;

    assign oob_in = (mem_addr >= LIMIT);
    assign err_d  = err_q | (accept & oob_in);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (accept && oob_in) begin
            $display("riscv_wait_mem: warning, out-of-range access at address 0x%08h", mem_addr);
        end
    end
`endif
`else
    assign oob_in  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        oob_d   = oob_q;
        we      = 1'b0;
        we_idx  = idx_q;
        we_data = wdata_q;
        we_mask = wmask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = idx_in;
                    wdata_d = mem_wdata;
                    wmask_d = mem_wmask;
                    oob_d   = oob_in;
                    if (WAIT_STATES == 0) begin
                        // A write beats a simultaneous read strobe; the read is discarded.
                        if (wr_req) begin
                            we      = ~oob_in;
                            we_idx  = idx_in;
                            we_data = mem_wdata;
                            we_mask = mem_wmask;
                        end else begin
                            rdata_d = oob_in ? 32'h0 : mem[idx_in];
                        end
                    end else begin
                        state_d = wr_req ? WAIT_WR : WAIT_RD;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT_RD: begin
                if (cnt_q == 4'd1) begin
                    rdata_d = oob_q ? 32'h0 : mem[idx_q];
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_WR: begin
                if (cnt_q == 4'd1) begin
                    we      = ~oob_q;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request capture needs no reset: it is only consumed after a fresh acceptance.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
        oob_q   <= oob_d;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (we_mask[k]) begin
                    mem[we_idx][8*k +: 8] <= we_data[8*k +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = (state_q == WAIT_RD);
    assign mem_wbusy = (state_q == WAIT_WR);

endmodule

// File: tb/tb_riscv_wait_mem.sv
// Scoreboard bench for riscv_wait_mem: one instance with no wait states and one with three.
module tb_riscv_wait_mem;

    localparam int K_RD = 0;
    localparam int K_RB = 1;
    localparam int K_WB = 2;
    localparam int K_ER = 3;

    typedef struct {
        int          due;
        int          which;
        int          kind;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] a0 = '0, wd0 = '0, a3 = '0, wd3 = '0;
    logic        r0 = 1'b0, r3 = 1'b0;
    logic [3:0]  wm0 = '0, wm3 = '0;
    logic [31:0] rd0, rd3;
    logic        rb0, wb0, er0, rb3, wb3, er3;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_wait_mem #(.DEPTH(256), .WAIT_STATES(0), .INIT_FILE("")) u0 (
        .clk(clk), .resetn(resetn), .mem_addr(a0), .mem_rstrb(r0),
        .mem_wdata(wd0), .mem_wmask(wm0), .mem_rdata(rd0),
        .mem_rbusy(rb0), .mem_wbusy(wb0), .mem_err(er0)
    );

    riscv_wait_mem #(.DEPTH(256), .WAIT_STATES(3), .INIT_FILE("")) u3 (
        .clk(clk), .resetn(resetn), .mem_addr(a3), .mem_rstrb(r3),
        .mem_wdata(wd3), .mem_wmask(wm3), .mem_rdata(rd3),
        .mem_rbusy(rb3), .mem_wbusy(wb3), .mem_err(er3)
    );

    function automatic logic [31:0] sample(input int which, input int kind);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_RD: v = (which == 0) ? rd0 : rd3;
            K_RB: v = {31'b0, (which == 0) ? rb0 : rb3};
            K_WB: v = {31'b0, (which == 0) ? wb0 : wb3};
            default: v = {31'b0, (which == 0) ? er0 : er3};
        endcase
        return v;
    endfunction

    // Monitor: every expectation is due at a given cycle and compared away from the active edge.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                got = sample(sb[i].which, sb[i].kind);
                if (got !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h", sb[i].nm, cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int due, input int which, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.due = due; e.which = which; e.kind = kind; e.exp = v; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reset_checks();
        push(cyc, 0, K_RD, 32'h0, "rst_rdata0");
        push(cyc, 0, K_RB, 32'h0, "rst_rbusy0");
        push(cyc, 0, K_WB, 32'h0, "rst_wbusy0");
        push(cyc, 0, K_ER, 32'h0, "rst_err0");
        push(cyc, 3, K_RD, 32'h0, "rst_rdata3");
        push(cyc, 3, K_RB, 32'h0, "rst_rbusy3");
        push(cyc, 3, K_WB, 32'h0, "rst_wbusy3");
        push(cyc, 3, K_ER, 32'h0, "rst_err3");
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        a0 = a; wd0 = wd; wm0 = wm;
        push(cyc + 1, 0, K_WB, 32'h0, "w0_wbusy");
        step();
        wm0 = 4'h0;
    endtask

    task automatic rd0_t(input logic [31:0] a, input logic [31:0] v, input string nm);
        a0 = a; r0 = 1'b1;
        push(cyc + 1, 0, K_RD, v, nm);
        push(cyc + 1, 0, K_RB, 32'h0, "r0_rbusy");
        step();
        r0 = 1'b0;
    endtask

    task automatic push_rd3(input int c, input logic [31:0] v, input logic [31:0] old, input string nm);
        for (int k = 1; k <= 3; k++) push(c + k, 3, K_RB, 32'h1, "r3_busy_hi");
        push(c + 1, 3, K_RD, old, "r3_rdata_held");
        push(c + 4, 3, K_RB, 32'h0, "r3_busy_lo");
        push(c + 4, 3, K_RD, v, nm);
    endtask

    task automatic rd3_t(input logic [31:0] a, input logic [31:0] v, input logic [31:0] old, input string nm);
        a3 = a; r3 = 1'b1;
        push_rd3(cyc, v, old, nm);
        step();
        r3 = 1'b0;
        step(); step(); step();
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] old);
        int c;
        c = cyc;
        a3 = a; wd3 = wd; wm3 = wm;
        for (int k = 1; k <= 3; k++) push(c + k, 3, K_WB, 32'h1, "w3_busy_hi");
        push(c + 4, 3, K_WB, 32'h0, "w3_busy_lo");
        push(c + 4, 3, K_RD, old, "w3_rdata_unchanged");
        step();
        wm3 = 4'h0;
        step(); step(); step();
    endtask

    initial begin
        int c;
        step(); step();
        push_reset_checks();
        step();
        resetn = 1'b1;
        step();

        // No wait states: full write then read back.
        wr0(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd0_t(32'h10, 32'hDEAD_BEEF, "w0_readback");

        // Byte-lane mask 0101 on word 2.
        wr0(32'h8, 32'h1234_5678, 4'hF);
        wr0(32'h8, 32'hAABB_CCDD, 4'b0101);
        rd0_t(32'h8, 32'h12BB_56DD, "bytemask_readback");

        // Simultaneous read strobe and write: write wins, rdata untouched.
        a0 = 32'h1C; wd0 = 32'h7777_7777; wm0 = 4'hF; r0 = 1'b1;
        push(cyc + 1, 0, K_RD, 32'h12BB_56DD, "simul_rdata_unchanged");
        push(cyc + 1, 0, K_RB, 32'h0, "simul_rbusy");
        step();
        wm0 = 4'h0; r0 = 1'b0;
        rd0_t(32'h1C, 32'h7777_7777, "simul_write_committed");

        // Address 0x400 past a 256-word array.
        wr0(32'h0, 32'h0BAD_F00D, 4'hF);
`ifdef MEM_BOUNDS_CHECK_EN
        rd0_t(32'h400, 32'h0, "oob_rdata_zero");
        push(cyc, 0, K_ER, 32'h1, "oob_err_set");
        step(); step(); step();
        push(cyc, 0, K_ER, 32'h1, "oob_err_sticky");
        step();
`else
        rd0_t(32'h400, 32'h0BAD_F00D, "wrap_rdata_word0");
        push(cyc, 0, K_ER, 32'h0, "wrap_err_low");
        step();
`endif

        // Three wait states: busy windows, back-to-back, ignored request while busy.
        wr3(32'h4, 32'h2222_2222, 4'hF, 32'h0);
        wr3(32'hC, 32'h3333_3333, 4'hF, 32'h0);
        c = cyc;
        a3 = 32'h4; r3 = 1'b1;
        push_rd3(c, 32'h2222_2222, 32'h0, "w3_read_word1");
        step();
        r3 = 1'b0;
        step();
        a3 = 32'hC; r3 = 1'b1;
        step();
        r3 = 1'b0;
        step();
        rd3_t(32'hC, 32'h3333_3333, 32'h2222_2222, "w3_read_after_ignored");
        wr3(32'hC, 32'h4444_4444, 4'hF, 32'h3333_3333);
        rd3_t(32'hC, 32'h4444_4444, 32'h3333_3333, "w3_read_after_write");

        // Reset in the middle of a pending write to word 5.
        wr3(32'h14, 32'h1111_1111, 4'hF, 32'h4444_4444);
        rd3_t(32'h14, 32'h1111_1111, 32'h4444_4444, "w3_word5_initial");
        c = cyc;
        a3 = 32'h14; wd3 = 32'h9999_9999; wm3 = 4'hF;
        push(c + 1, 3, K_WB, 32'h1, "midwrite_busy");
        step();
        wm3 = 4'h0;
        step();
        resetn = 1'b0;
        push_reset_checks();
        step(); step();
        resetn = 1'b1;
        rd3_t(32'h14, 32'h1111_1111, 32'h0, "reset_dropped_write");
        step(); step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
